// File: rtl/i2c_wb_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package  : i2c_seq_pkg
// Brief    : Shared constants, enums and helpers for the I2C Wishbone sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package i2c_seq_pkg;

    localparam logic [2:0] c_ADR_PRERLO  = 3'd0;
    localparam logic [2:0] c_ADR_PRERHI  = 3'd1;
    localparam logic [2:0] c_ADR_CTR     = 3'd2;
    localparam logic [2:0] c_ADR_TXR_RXR = 3'd3;
    localparam logic [2:0] c_ADR_CR_SR   = 3'd4;

    localparam logic [7:0] c_CTR_EN         = 8'h80;
    localparam logic [7:0] c_CMD_STA_WR     = 8'h90;
    localparam logic [7:0] c_CMD_WR         = 8'h10;
    localparam logic [7:0] c_CMD_STO_WR     = 8'h50;
    localparam logic [7:0] c_CMD_RD_ACK_STO = 8'h68;
    localparam logic [7:0] c_CMD_STO        = 8'h40;

    localparam int c_SR_TIP   = 1;
    localparam int c_SR_AL    = 5;
    localparam int c_SR_BUSY  = 6;
    localparam int c_SR_RXACK = 7;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_NACK    = 2'd1,
        ERR_ARB     = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_e;

    typedef enum logic [3:0] {
        INIT_PLO   = 4'd0,
        INIT_PHI   = 4'd1,
        INIT_CTR   = 4'd2,
        IDLE       = 4'd3,
        TX_WR      = 4'd4,
        CR_WR      = 4'd5,
        WAIT       = 4'd6,
        RX_RD      = 4'd7,
        ABORT      = 4'd8,
        ABORT_WAIT = 4'd9,
        DONE       = 4'd10
    } state_e;

    // Phases 0..2 are byte writes; phase 3 is the read byte of a read request.
    function automatic logic [7:0] cr_cmd(input logic [1:0] phase, input logic rnw);
        case (phase)
            2'd0:    cr_cmd = c_CMD_STA_WR;
            2'd1:    cr_cmd = c_CMD_WR;
            2'd2:    cr_cmd = rnw ? c_CMD_STA_WR : c_CMD_STO_WR;
            default: cr_cmd = c_CMD_RD_ACK_STO;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_wb_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface: i2c_wb_sequencer_if
// Brief    : 8-bit Wishbone link between the sequencer and the I2C controller.
// Revision : 1.0 - initial release
// ============================================================================
interface i2c_wb_sequencer_if;
    logic [2:0] wbm_adr_o;
    logic [7:0] wbm_dat_o;
    logic [7:0] wbm_dat_i;
    logic       wbm_we_o;
    logic       wbm_stb_o;
    logic       wbm_cyc_o;
    logic       wbm_ack_i;

    modport master (
        output wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_stb_o, wbm_cyc_o,
        input  wbm_dat_i, wbm_ack_i
    );

    modport slave (
        input  wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_stb_o, wbm_cyc_o,
        output wbm_dat_i, wbm_ack_i
    );
endinterface
`default_nettype wire

// File: rtl/i2c_wb_sequencer_access.sv
`default_nettype none
// ============================================================================
// Module   : i2c_wb_access
// Brief    : Single-beat Wishbone master; one access per start, done pulses after ack.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_wb_access (
    input  wire        wb_clk_i,
    input  wire        wb_rst_i,
    input  wire        i_start,
    input  wire        i_we,
    input  wire  [2:0] i_adr,
    input  wire  [7:0] i_dat,
    output logic       o_done,
    output logic [7:0] o_rdata,
    i2c_wb_sequencer_if.master wbm
);
    logic       r_cyc;
    logic       r_we;
    logic       r_done;
    logic [2:0] r_adr;
    logic [7:0] r_dat;
    logic [7:0] r_rdata;

    // Dropping cyc on the ack edge guarantees an idle cycle before the next start.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_done  <= 1'b0;
            r_adr   <= 3'd0;
            r_dat   <= 8'h00;
            r_rdata <= 8'h00;
        end else begin
            r_done <= 1'b0;
            if (r_cyc) begin
                if (wbm.wbm_ack_i) begin
                    r_cyc  <= 1'b0;
                    r_done <= 1'b1;
                    if (!r_we) begin
                        r_rdata <= wbm.wbm_dat_i;
                    end
                end
            end else if (i_start) begin
                r_cyc <= 1'b1;
                r_we  <= i_we;
                r_adr <= i_adr;
                r_dat <= i_dat;
            end
        end
    end

    assign wbm.wbm_cyc_o = r_cyc;
    assign wbm.wbm_stb_o = r_cyc;
    assign wbm.wbm_we_o  = r_we;
    assign wbm.wbm_adr_o = r_adr;
    assign wbm.wbm_dat_o = r_dat;
    assign o_done        = r_done;
    assign o_rdata       = r_rdata;
endmodule
`default_nettype wire

// File: rtl/i2c_wb_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : i2c_wb_sequencer
// Brief    : Turns single register read/write requests into I2C controller accesses.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_wb_sequencer
    import i2c_seq_pkg::*;
#(
    parameter logic [15:0] PRESCALE   = 16'h0063,
    parameter int          POLL_LIMIT = 4096
) (
    input  wire        wb_clk_i,
    input  wire        wb_rst_i,
    input  wire        req_valid_i,
    output logic       req_ready_o,
    input  wire        req_rnw_i,
    input  wire  [6:0] req_dev_i,
    input  wire  [7:0] req_reg_i,
    input  wire  [7:0] req_wdata_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_rdata_o,
    output logic [1:0] rsp_err_o,
    i2c_wb_sequencer_if.master wbm
);
    localparam int                 c_CNT_W     = $clog2(POLL_LIMIT) + 1;
    localparam logic [c_CNT_W-1:0] c_POLL_LAST = c_CNT_W'(POLL_LIMIT - 1);

    state_e             r_state, w_state_next;
    logic               r_first;
    logic [1:0]         r_phase, w_phase_next;
    logic [c_CNT_W-1:0] r_poll, w_poll_next;
    err_e               r_err, w_err_next;
    logic [7:0]         r_rdata, w_rdata_next;
    logic               r_rnw;
    logic [6:0]         r_dev;
    logic [7:0]         r_reg;
    logic [7:0]         r_wdata;
    logic [1:0]         r_rsp_err;
    logic [7:0]         r_rsp_rdata;

    logic       w_accept;
    logic       w_acc_start, w_acc_we, w_acc_done;
    logic [2:0] w_acc_adr;
    logic [7:0] w_acc_dat, w_acc_rdata;

    assign w_accept = (r_state == IDLE) && req_valid_i;

    i2c_wb_access u_access (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .i_start  (w_acc_start),
        .i_we     (w_acc_we),
        .i_adr    (w_acc_adr),
        .i_dat    (w_acc_dat),
        .o_done   (w_acc_done),
        .o_rdata  (w_acc_rdata),
        .wbm      (wbm)
    );

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            r_state     <= INIT_PLO;
            r_first     <= 1'b1;
            r_phase     <= 2'd0;
            r_poll      <= '0;
            r_err       <= ERR_OK;
            r_rdata     <= 8'h00;
            r_rnw       <= 1'b0;
            r_dev       <= 7'd0;
            r_reg       <= 8'h00;
            r_wdata     <= 8'h00;
            r_rsp_err   <= 2'd0;
            r_rsp_rdata <= 8'h00;
        end else begin
            r_state <= w_state_next;
            r_first <= 1'b0;
            r_phase <= w_phase_next;
            r_poll  <= w_poll_next;
            r_err   <= w_err_next;
            r_rdata <= w_rdata_next;
            if (w_accept) begin
                r_rnw   <= req_rnw_i;
                r_dev   <= req_dev_i;
                r_reg   <= req_reg_i;
                r_wdata <= req_wdata_i;
            end
            // Response fields only move on DONE entry so they stay stable between pulses.
            if (w_state_next == DONE && r_state != DONE) begin
                r_rsp_err   <= w_err_next;
                r_rsp_rdata <= w_rdata_next;
            end
        end
    end

    // Each transition into an access state issues that state's access in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_phase_next = r_phase;
        w_poll_next  = r_poll;
        w_err_next   = r_err;
        w_rdata_next = r_rdata;
        w_acc_start  = 1'b0;
        w_acc_we     = 1'b0;
        w_acc_adr    = c_ADR_PRERLO;
        w_acc_dat    = 8'h00;
        case (r_state)
            INIT_PLO: begin
                if (r_first) begin
                    w_acc_start = 1'b1; w_acc_we = 1'b1;
                    w_acc_adr = c_ADR_PRERLO; w_acc_dat = PRESCALE[7:0];
                end else if (w_acc_done) begin
                    w_state_next = INIT_PHI;
                    w_acc_start = 1'b1; w_acc_we = 1'b1;
                    w_acc_adr = c_ADR_PRERHI; w_acc_dat = PRESCALE[15:8];
                end
            end
            INIT_PHI: if (w_acc_done) begin
                w_state_next = INIT_CTR;
                w_acc_start = 1'b1; w_acc_we = 1'b1;
                w_acc_adr = c_ADR_CTR; w_acc_dat = c_CTR_EN;
            end
            INIT_CTR: if (w_acc_done) w_state_next = IDLE;
            IDLE: if (req_valid_i) begin
                w_state_next = TX_WR;
                w_phase_next = 2'd0;
                w_err_next   = ERR_OK;
                w_acc_start = 1'b1; w_acc_we = 1'b1;
                w_acc_adr = c_ADR_TXR_RXR; w_acc_dat = {req_dev_i, 1'b0};
            end
            TX_WR: if (w_acc_done) begin
                w_state_next = CR_WR;
                w_acc_start = 1'b1; w_acc_we = 1'b1;
                w_acc_adr = c_ADR_CR_SR; w_acc_dat = cr_cmd(r_phase, r_rnw);
            end
            CR_WR: if (w_acc_done) begin
                w_state_next = WAIT;
                w_poll_next  = '0;
                w_acc_start = 1'b1; w_acc_adr = c_ADR_CR_SR;
            end
            WAIT: if (w_acc_done) begin
                if (w_acc_rdata[c_SR_TIP]) begin
                    if (r_poll == c_POLL_LAST) begin
                        w_err_next   = ERR_TIMEOUT;
                        w_state_next = ABORT;
                        w_acc_start = 1'b1; w_acc_we = 1'b1;
                        w_acc_adr = c_ADR_CR_SR; w_acc_dat = c_CMD_STO;
                    end else begin
                        w_poll_next = r_poll + 1'b1;
                        w_acc_start = 1'b1; w_acc_adr = c_ADR_CR_SR;
                    end
                end else if (w_acc_rdata[c_SR_AL]) begin
                    w_err_next   = ERR_ARB;
                    w_state_next = DONE;
                end else if (r_phase != 2'd3 && w_acc_rdata[c_SR_RXACK]) begin
                    w_err_next   = ERR_NACK;
                    w_state_next = ABORT;
                    w_acc_start = 1'b1; w_acc_we = 1'b1;
                    w_acc_adr = c_ADR_CR_SR; w_acc_dat = c_CMD_STO;
                end else if (r_phase == 2'd3) begin
                    w_state_next = RX_RD;
                    w_acc_start = 1'b1; w_acc_adr = c_ADR_TXR_RXR;
                end else if (r_phase == 2'd2 && !r_rnw) begin
                    w_state_next = DONE;
                end else if (r_phase == 2'd2) begin
                    w_phase_next = 2'd3;
                    w_state_next = CR_WR;
                    w_acc_start = 1'b1; w_acc_we = 1'b1;
                    w_acc_adr = c_ADR_CR_SR; w_acc_dat = c_CMD_RD_ACK_STO;
                end else begin
                    w_phase_next = r_phase + 2'd1;
                    w_state_next = TX_WR;
                    w_acc_start = 1'b1; w_acc_we = 1'b1;
                    w_acc_adr = c_ADR_TXR_RXR;
                    w_acc_dat = (r_phase == 2'd0) ? r_reg : (r_rnw ? {r_dev, 1'b1} : r_wdata);
                end
            end
            RX_RD: if (w_acc_done) begin
                w_rdata_next = w_acc_rdata;
                w_state_next = DONE;
            end
            ABORT: if (w_acc_done) begin
                w_state_next = ABORT_WAIT;
                w_poll_next  = '0;
                w_acc_start = 1'b1; w_acc_adr = c_ADR_CR_SR;
            end
            ABORT_WAIT: if (w_acc_done) begin
                if (w_acc_rdata[c_SR_BUSY] && r_poll != c_POLL_LAST) begin
                    w_poll_next = r_poll + 1'b1;
                    w_acc_start = 1'b1; w_acc_adr = c_ADR_CR_SR;
                end else begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = INIT_PLO;
        endcase
    end

    assign req_ready_o = (r_state == IDLE);
    assign rsp_valid_o = (r_state == DONE);
    assign rsp_err_o   = r_rsp_err;
    assign rsp_rdata_o = r_rsp_rdata;
endmodule
`default_nettype wire

// File: tb/tb_i2c_wb_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_wb_sequencer
// Brief    : Self-checking bench with a controller model and access/response scoreboards.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_wb_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_rnw;
    logic [6:0] req_dev;
    logic [7:0] req_reg, req_wdata;
    logic       req_ready, rsp_valid;
    logic [7:0] rsp_rdata;
    logic [1:0] rsp_err;

    always #5 clk = ~clk;

    i2c_wb_sequencer_if wbm ();

    i2c_wb_sequencer #(.PRESCALE(16'h0063), .POLL_LIMIT(8)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_rnw_i   (req_rnw),
        .req_dev_i   (req_dev),
        .req_reg_i   (req_reg),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .wbm         (wbm)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int n_rsp = 0;
    logic [10:0] exp_wr[$];
    logic [10:0] exp_rsp[$];
    logic [10:0] e_wr, e_rsp;

    // Controller model knobs
    int         tip_polls = 0, busy_polls = 0, sr_cnt = 0, sr_before_cr = 0;
    logic [7:0] sr_final = 8'h00, rxr_val = 8'h00, rd_word = 8'h00;
    logic       in_abort = 1'b0;
    logic       ack = 1'b0;

    assign wbm.wbm_ack_i = ack;
    assign wbm.wbm_dat_i = rd_word;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) ack <= wbm.wbm_cyc_o && wbm.wbm_stb_o && !ack;

    always @(negedge clk) begin
        if (wbm.wbm_cyc_o && wbm.wbm_stb_o && !ack && !wbm.wbm_we_o) begin
            if (wbm.wbm_adr_o == 3'd4)
                rd_word = in_abort ? ((sr_cnt < busy_polls) ? 8'h40 : 8'h00)
                                   : ((sr_cnt < tip_polls) ? 8'h02 : sr_final);
            else if (wbm.wbm_adr_o == 3'd3)
                rd_word = rxr_val;
            else
                rd_word = 8'h00;
        end
        if (wbm.wbm_cyc_o && wbm.wbm_stb_o && ack) begin
            if (wbm.wbm_we_o) begin
                check("wr_expected", 16'(exp_wr.size() != 0), 16'd1);
                if (exp_wr.size() != 0) begin
                    e_wr = exp_wr.pop_front();
                    check("wr_adr_dat", {5'd0, wbm.wbm_adr_o, wbm.wbm_dat_o}, {5'd0, e_wr});
                end
                if (wbm.wbm_adr_o == 3'd4) begin
                    in_abort     = (wbm.wbm_dat_o == 8'h40);
                    sr_before_cr = sr_cnt;
                    sr_cnt       = 0;
                end
            end else if (wbm.wbm_adr_o == 3'd4) begin
                sr_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (rsp_valid) begin
            n_rsp++;
            check("rsp_expected", 16'(exp_rsp.size() != 0), 16'd1);
            if (exp_rsp.size() != 0) begin
                e_rsp = exp_rsp.pop_front();
                check("rsp_err", 16'(rsp_err), 16'(e_rsp[9:8]));
                if (e_rsp[10]) check("rsp_rdata", 16'(rsp_rdata), 16'(e_rsp[7:0]));
            end
        end
    end

    task automatic push_wr(input logic [2:0] a, input logic [7:0] d);
        exp_wr.push_back({a, d});
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!req_ready && t < 200) begin @(negedge clk); t++; end
        check("req_ready", 16'(req_ready), 16'd1);
    endtask

    task automatic send_req(input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                            input logic [7:0] wd);
        @(negedge clk);
        req_valid = 1'b1; req_rnw = rnw; req_dev = dev; req_reg = rg; req_wdata = wd;
        wait_ready();
        @(negedge clk);
        req_valid = 1'b0; req_rnw = ~rnw; req_dev = ~dev; req_reg = ~rg; req_wdata = ~wd;
    endtask

    task automatic wait_rsp(input int n0);
        int t = 0;
        while (n_rsp == n0 && t < 2000) begin @(negedge clk); t++; end
        check("rsp_arrived", 16'(n_rsp != n0), 16'd1);
        check("wr_queue_drained", 16'(exp_wr.size()), 16'd0);
    endtask

    initial begin
        int n0;
        int t;
        rst_n = 1'b0; req_valid = 1'b0; req_rnw = 1'b0;
        req_dev = 7'd0; req_reg = 8'h00; req_wdata = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_cyc", 16'(wbm.wbm_cyc_o), 16'd0);
        check("rst_stb", 16'(wbm.wbm_stb_o), 16'd0);
        check("rst_ready", 16'(req_ready), 16'd0);
        check("rst_rsp_valid", 16'(rsp_valid), 16'd0);
        check("rst_rsp_err", 16'(rsp_err), 16'd0);
        check("rst_rsp_rdata", 16'(rsp_rdata), 16'd0);

        push_wr(3'd0, 8'h63); push_wr(3'd1, 8'h00); push_wr(3'd2, 8'h80);
        rst_n = 1'b1;
        wait_ready();
        check("init_drained", 16'(exp_wr.size()), 16'd0);

        // Write with ACKs, TIP clearing after 3 polls
        tip_polls = 3;
        push_wr(3'd3, 8'hA0); push_wr(3'd4, 8'h90);
        push_wr(3'd3, 8'h10); push_wr(3'd4, 8'h10);
        push_wr(3'd3, 8'hA5); push_wr(3'd4, 8'h50);
        exp_rsp.push_back({1'b0, 2'd0, 8'h00});
        n0 = n_rsp; send_req(1'b0, 7'h50, 8'h10, 8'hA5); wait_rsp(n0);

        // Read
        rxr_val = 8'h3C;
        push_wr(3'd3, 8'hA0); push_wr(3'd4, 8'h90);
        push_wr(3'd3, 8'h02); push_wr(3'd4, 8'h10);
        push_wr(3'd3, 8'hA1); push_wr(3'd4, 8'h90);
        push_wr(3'd4, 8'h68);
        exp_rsp.push_back({1'b1, 2'd0, 8'h3C});
        n0 = n_rsp; send_req(1'b1, 7'h50, 8'h02, 8'h00); wait_rsp(n0);

        // Address NACK then STOP with two busy polls
        sr_final = 8'h80; busy_polls = 2;
        push_wr(3'd3, 8'hA0); push_wr(3'd4, 8'h90); push_wr(3'd4, 8'h40);
        exp_rsp.push_back({1'b0, 2'd1, 8'h00});
        n0 = n_rsp; send_req(1'b0, 7'h50, 8'h10, 8'h11); wait_rsp(n0);
        check("nack_busy_reads", 16'(sr_cnt), 16'd3);

        // Arbitration lost: no STOP, read data from last read held
        sr_final = 8'h20;
        push_wr(3'd3, 8'hA0); push_wr(3'd4, 8'h90);
        exp_rsp.push_back({1'b0, 2'd2, 8'h00});
        n0 = n_rsp; send_req(1'b1, 7'h50, 8'h02, 8'h00); wait_rsp(n0);
        check("al_rdata_held", 16'(rsp_rdata), 16'h003C);

        // TIP stuck: exactly POLL_LIMIT SR reads then STOP
        sr_final = 8'h00; tip_polls = 1000; busy_polls = 0;
        push_wr(3'd3, 8'hA0); push_wr(3'd4, 8'h90); push_wr(3'd4, 8'h40);
        exp_rsp.push_back({1'b0, 2'd3, 8'h00});
        n0 = n_rsp; send_req(1'b0, 7'h50, 8'h10, 8'h22); wait_rsp(n0);
        check("timeout_sr_reads", 16'(sr_before_cr), 16'd8);

        // NACK then Busy stuck: abort poll gives up, first error kept
        tip_polls = 0; sr_final = 8'h80; busy_polls = 1000;
        push_wr(3'd3, 8'hA0); push_wr(3'd4, 8'h90); push_wr(3'd4, 8'h40);
        exp_rsp.push_back({1'b0, 2'd1, 8'h00});
        n0 = n_rsp; send_req(1'b0, 7'h50, 8'h10, 8'h33); wait_rsp(n0);
        check("abort_sr_reads", 16'(sr_cnt), 16'd8);

        // Reset in the middle of an SR read
        tip_polls = 1000; sr_final = 8'h00; busy_polls = 0;
        push_wr(3'd3, 8'hA0); push_wr(3'd4, 8'h90);
        send_req(1'b1, 7'h50, 8'h02, 8'h00);
        t = 0;
        while (!(wbm.wbm_stb_o && !wbm.wbm_we_o && !ack) && t < 200) begin @(negedge clk); t++; end
        check("mid_read_found", 16'(wbm.wbm_stb_o && !wbm.wbm_we_o), 16'd1);
        check("mid_read_drained", 16'(exp_wr.size()), 16'd0);
        push_wr(3'd0, 8'h63); push_wr(3'd1, 8'h00); push_wr(3'd2, 8'h80);
        n0 = n_rsp;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_cyc", 16'(wbm.wbm_cyc_o), 16'd0);
        check("rst_mid_stb", 16'(wbm.wbm_stb_o), 16'd0);
        rst_n = 1'b1;
        wait_ready();
        check("rst_mid_no_rsp", 16'(n_rsp), 16'(n0));
        check("rst_mid_init_drained", 16'(exp_wr.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/i2c_wb_sequencer.md
Name: i2c_wb_sequencer

Overview:
- Wishbone master that sits directly upstream of the I2C master controller. It drives that controller's 8-bit Wishbone slave port (PRER/CTR/TXR/CR writes, RXR/SR reads).
- Converts a single-beat register request (device address, register index, data, read/write) into the complete sequence of controller register accesses.
- Returns a result with read data and an error code, so system logic never handles the I2C bit-level protocol.

Parameters:
- PRESCALE, 16'h0063, value loaded into PRERhi:PRERlo at init (50 MHz clock, 100 kHz SCL).
- POLL_LIMIT, 4096, maximum number of SR reads per wait before a timeout is declared.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  synchronous, active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  sequencer idle; request accepted on valid&ready.
- req_rnw_i  in  1  1 = read, 0 = write.
- req_dev_i  in  7  7-bit I2C device address.
- req_reg_i  in  8  device register index.
- req_wdata_i  in  8  write data.
- rsp_valid_o  out  1  one-cycle completion pulse.
- rsp_rdata_o  out  8  read data; valid with rsp_valid_o when rnw=1 and err=0.
- rsp_err_o  out  2  0 OK, 1 NACK, 2 arbitration lost, 3 poll timeout.
- wbm_adr_o  out  3  controller register address.
- wbm_dat_o  out  8  write data to controller.
- wbm_dat_i  in  8  read data from controller.
- wbm_we_o  out  1  write enable.
- wbm_stb_o  out  1  strobe.
- wbm_cyc_o  out  1  cycle.
- wbm_ack_i  in  1  controller acknowledge.

Behaviour:
- Reset (wb_rst_i=0 at clock edge):
  - All outputs 0, rsp_rdata_o=0, state=INIT_PLO.
  - Any Wishbone access in flight is dropped; cyc/stb fall on the next edge.
- Wishbone access:
  - adr/dat/we/cyc/stb are driven together and held until wbm_ack_i=1.
  - cyc and stb drop in the cycle after ack.
  - At least one idle cycle separates accesses.
  - Read data is captured on the ack edge.
- Register addresses: 0 PRERlo, 1 PRERhi, 2 CTR, 3 TXR (write) / RXR (read), 4 CR (write) / SR (read).
- Command bytes:
  - 0x90: STA|WR.
  - 0x10: WR.
  - 0x50: STO|WR.
  - 0x68: RD|ACK|STO.
  - 0x40: STO.
- Init sequence: write PRERlo=PRESCALE[7:0], then PRERhi=PRESCALE[15:8], then CTR=0x80 (EN=1, IEN=0), then go to IDLE.
  - req_ready_o=1 only in IDLE.
- Write request sequence:
  - TXR={dev,0}, CR=0x90, WAIT.
  - TXR=reg, CR=0x10, WAIT.
  - TXR=wdata, CR=0x50, WAIT.
  - DONE.
- Read request sequence:
  - TXR={dev,0}, CR=0x90, WAIT.
  - TXR=reg, CR=0x10, WAIT.
  - TXR={dev,1}, CR=0x90 (repeated start), WAIT.
  - CR=0x68, WAIT.
  - Read RXR into rsp_rdata_o.
  - DONE.
- WAIT state:
  - Read SR repeatedly until SR[1] (TIP)=0.
  - Then, if SR[5] (AL)=1, set err=2 and go directly to DONE; no STOP is issued.
  - Else, if SR[7] (RxACK)=1 after any WR phase, set err=1 and go to ABORT.
  - The RxACK check is skipped after the RD phase (master NACK is intended).
- ABORT: write CR=0x40, poll SR until SR[6] (Busy)=0, then go to DONE.
- Timeout:
  - Poll counter resets on entry to each WAIT or ABORT poll.
  - When the POLL_LIMIT-th SR read still shows the wait condition: in WAIT, set err=3 and go to ABORT; in ABORT, go to DONE with err=3 kept.
  - The counter saturates and never wraps.
- DONE:
  - rsp_valid_o=1 for exactly one cycle, with rsp_err_o and rsp_rdata_o held stable until the next DONE.
  - Next state is IDLE; req_ready_o rises the following cycle.
- Request handshake:
  - Request fields are registered on acceptance; later input changes are ignored.
  - req_valid_i outside IDLE is ignored (not queued).
- Back-to-back: a request accepted in the first IDLE cycle starts its first TXR write on the following cycle.
- The first error detected wins; AL takes priority over NACK in the same SR sample.

Decomposition:
- Package i2c_seq_pkg:
  - Register address localparams.
  - CR command constants.
  - SR bit indices.
  - err code enum.
  - State enum (INIT_PLO, INIT_PHI, INIT_CTR, IDLE, TX_WR, CR_WR, WAIT, RX_RD, ABORT, ABORT_WAIT, DONE).
- Sub-module i2c_wb_access: single-access Wishbone master with start/we/adr/dat in and done/rdata out. The main FSM sequences through it.

Test Plan:
- Reset release with ack after 1 cycle → writes in order: adr0=0x63, adr1=0x00, adr2=0x80; req_ready_o=1 afterwards.
- Write dev=0x50, reg=0x10, data=0xA5, model always ACKs, TIP clears after 3 polls → TXR sequence 0xA0/0x10/0xA5, CR sequence 0x90/0x10/0x50; rsp_err_o=0.
- Read dev=0x50, reg=0x02, RXR=0x3C → TXR sequence 0xA0/0x02/0xA1, CR sequence 0x90/0x10/0x90/0x68; rsp_rdata_o=0x3C, err=0.
- Address NACK (SR=0x80 after first WAIT) → CR=0x40 written, Busy polled to 0; err=1, no further TXR writes.
- TIP stuck at 1 with POLL_LIMIT=8 → exactly 8 SR reads, then CR=0x40; err=3.
- Reset asserted mid-read while stb=1 → cyc/stb=0 next cycle, init sequence replays, no rsp_valid_o pulse.
